// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// The states are IDLE, RUN and DONE.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;

  localparam int SADD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders and an OR for the carry.
// The serial adder controller steps this one cell LSB-first, one bit per cycle.
module ha_cell (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B;
  assign Cout = A & B;

endmodule

module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic halfSum;
  logic halfCarry0;
  logic halfCarry1;

  ha_cell u_ha0 (
    .A    (A),
    .B    (B),
    .Sum  (halfSum),
    .Cout (halfCarry0)
  );

  ha_cell u_ha1 (
    .A    (halfSum),
    .B    (Cin),
    .Sum  (Sum),
    .Cout (halfCarry1)
  );

  // The two half-adder carries can never both be set, so an OR is enough.
  assign Cout = halfCarry0 | halfCarry1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: takes A+B+cin over a valid/ready handshake, runs WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output 'ovf'.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = SADD_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  sadd_state_t      state_q, state_d;
  logic [WIDTH-1:0] shiftA_q, shiftA_d;
  logic [WIDTH-1:0] shiftB_q, shiftB_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             carryOut_q, carryOut_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow_q, overflow_d;
`endif

  logic faSum;
  logic faCout;
  logic accept;
  logic lastBit;

  fa_cell u_fa (
    .A    (shiftA_q[0]),
    .B    (shiftB_q[0]),
    .Cin  (carry_q),
    .Sum  (faSum),
    .Cout (faCout)
  );

  // in_ready depends combinationally on out_ready, so a new operand pair can be taken on the result's completion edge.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign lastBit   = (bitCnt_q == CNT_W'(WIDTH - 1));

  assign sum  = result_q;
  assign cout = carryOut_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = overflow_q;
`endif

  always_comb begin
    state_d    = state_q;
    shiftA_d   = shiftA_q;
    shiftB_d   = shiftB_q;
    result_d   = result_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    bitCnt_d   = bitCnt_q;
`ifdef SERIAL_ADD_OVF_EN
    overflow_d = overflow_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = RUN;
          shiftA_d = a;
          shiftB_d = b;
          carry_d  = cin;
          bitCnt_d = '0;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        shiftA_d = shiftA_q >> 1;
        shiftB_d = shiftB_q >> 1;
        result_d = {faSum, result_q[WIDTH-1:1]};
        carry_d  = faCout;
        bitCnt_d = bitCnt_q + CNT_W'(1);
        // On the MSB step carry_q is the carry into the MSB and faCout the carry out.
        if (lastBit) begin
          state_d    = DONE;
          carryOut_d = faCout;
`ifdef SERIAL_ADD_OVF_EN
          overflow_d = carry_q ^ faCout;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shiftA_q   <= '0;
      shiftB_q   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      bitCnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shiftA_q   <= shiftA_d;
      shiftB_q   <= shiftB_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
      bitCnt_q   <= bitCnt_d;
`ifdef SERIAL_ADD_OVF_EN
      overflow_q <= overflow_d;
`endif
    end
  end

endmodule
